// File: rtl/uart_tx.sv
// uart_tx: 8O1 UART transmitter (start, 8 data LSB first, odd parity, stop).
// Define UART_TX_TWO_STOP_EN to transmit a second stop bit.
module uart_tx #(
  parameter int BAUD_CYCLES = 5208,
  parameter int DATA_BITS   = 8
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       Send,
  input  logic [7:0] Din,
  output logic       Sout,
  output logic       Sent,
  output logic       Busy
);

  localparam int TW = $clog2(BAUD_CYCLES);
  localparam logic [TW-1:0] TMAX = TW'(BAUD_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_STOP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // bit index 9 ends parity; the stop phase then counts 10 (and 11)
  localparam logic [3:0] IDX_PAR  = 4'd9;
`ifdef UART_TX_TWO_STOP_EN
  localparam logic [3:0] IDX_LAST = 4'd11;
`else
  localparam logic [3:0] IDX_LAST = 4'd10;
`endif

  if (BAUD_CYCLES < 4 || DATA_BITS != 8) begin : g_bad_cfg
    $error("uart_tx: BAUD_CYCLES must be >= 4 and DATA_BITS must be 8");
  end

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    idx_q,   idx_d;
  logic [9:0]    frame_q, frame_d;
  logic          sout_q,  sout_d;
  logic          sent_q,  sent_d;
  logic          busy_q,  busy_d;
  logic          tick;

  assign tick = (state_q == S_DATA || state_q == S_STOP)
                && (timer_q == TMAX);

  // next-state logic; outputs are derived from the next state
  always_comb begin
    state_d = state_q;
    timer_d = '0;
    idx_d   = idx_q;
    frame_d = frame_q;
    case (state_q)
      S_IDLE: begin
        if (Send) begin
          frame_d = {~^Din, Din, 1'b0};
          idx_d   = 4'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        timer_d = tick ? '0 : timer_q + TW'(1);
        if (tick) begin
          frame_d = {1'b0, frame_q[9:1]};
          idx_d   = idx_q + 4'd1;
          if (idx_q == IDX_PAR) state_d = S_STOP;
        end
      end
      S_STOP: begin
        timer_d = tick ? '0 : timer_q + TW'(1);
        if (tick) begin
          if (idx_q == IDX_LAST) begin
            idx_d   = 4'd0;
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      S_DONE: begin
        if (!Send) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = 4'd0;
        frame_d = '0;
      end
    endcase
    sout_d = (state_d == S_DATA) ? frame_d[0] : 1'b1;
    sent_d = (state_d == S_DONE);
    busy_d = (state_d == S_DATA) || (state_d == S_STOP);
  end

  // state and registered outputs; reset idles the line at once
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      idx_q   <= 4'd0;
      frame_q <= '0;
      sout_q  <= 1'b1;
      sent_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      sout_q  <= sout_d;
      sent_q  <= sent_d;
      busy_q  <= busy_d;
    end
  end

  assign Sout = sout_q;
  assign Sent = sent_q;
  assign Busy = busy_q;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter; transmit-side counterpart of the 8O1 serial receiver already in the design.
- Serialises one byte per request as: start bit, 8 data bits LSB first, odd parity bit, stop bit.
- Default bit period is 5208 clk cycles (19200 baud at 100 MHz).
- Level handshake with the host logic: Send / Sent. Drives the serial line Sout.

Parameters:
- BAUD_CYCLES, 5208, clk cycles per bit period; legal range >= 4.
- DATA_BITS, 8, data bits per frame. Fixed at 8; other values are not supported.

Ports:
- clk    input   1  system clock; all state updates on posedge.
- Reset  input   1  asynchronous, active-high reset.
- Send   input   1  transmit request; level; host holds high until Sent is seen.
- Din    input   8  byte to transmit; sampled only on the cycle a request is accepted.
- Sout   output  1  serial line; idle/mark = 1.
- Sent   output  1  frame complete; high until Send drops.
- Busy   output  1  high from request acceptance until Sent asserts.

Behaviour:
- Reset (async, active-high) forces:
  - state IDLE
  - Sout=1, Sent=0, Busy=0
  - bit timer=0, bit index=0, shift register=0
- Reset asserted mid-frame aborts the frame immediately; Sout returns to 1 without waiting for a clock edge.
- All outputs are registered; none depends combinationally on an input.
- Bit timer: counts 0..BAUD_CYCLES-1. tick=1 when count==BAUD_CYCLES-1; the counter wraps to 0 on tick. Width is $clog2(BAUD_CYCLES).
- Frame register, 10 bits: {parity, Din[7:0], 0}, loaded at acceptance.
  - parity = ~^Din, so the 9 bits {parity, data} hold an odd number of ones.
- State machine:
  - IDLE: Sout=1, timer held at 0. If Send=1 on an edge: load frame register, clear bit index, go to DATA. Busy=1 from the next cycle.
  - DATA: Sout=frame[0]. On each tick: shift frame right by 1, bit index +1. On the tick where bit index==9 (the parity bit is done), go to STOP.
    - Start bit, D0..D7 and parity each last exactly BAUD_CYCLES cycles.
  - STOP: Sout=1 for BAUD_CYCLES cycles. On tick go to DONE; Sent=1 and Busy=0 from the next cycle.
  - DONE: Sout=1, Sent=1. When Send=0, go to IDLE; Sent=0 the next cycle.
- Latency: Sout falls 1 cycle after the accepting edge. A frame is 11*BAUD_CYCLES cycles of line activity (57288 at default). Sent rises 1 cycle after the last stop-bit cycle.
- Send held high continuously gives exactly one frame. No retransmit until Send has been seen low in DONE.
- Send dropped before DONE: the frame still completes; Sent pulses for 1 cycle, then the block returns to IDLE.
- Din changing after acceptance has no effect on the frame in flight.
- Back-to-back frames: minimum gap between stop-bit end and the next start bit is 2 cycles (DONE -> IDLE -> accept).
- Unreachable state encodings recover to IDLE with Sout=1.

Optional Feature:
- Macro: UART_TX_TWO_STOP_EN.
- Defined: STOP lasts 2*BAUD_CYCLES cycles (second stop bit, also 1). Frame is 12*BAUD_CYCLES cycles; Sent timing shifts accordingly.
- Undefined: single stop bit as described above.
- The macro changes no ports and no other behaviour.

Test Plan:
- Reset idle: assert Reset for 3 cycles, release, hold Send=0 for 20000 cycles -> Sout=1, Sent=0, Busy=0 throughout.
- Single frame Din=0x41: raise Send, sample Sout at mid-bit (offset 2604 + k*5208) -> 0,1,0,0,0,0,0,1,0,1(parity),1(stop). Sent rises 57289 cycles after acceptance and drops 1 cycle after Send=0.
- Parity check Din=0x01 -> parity bit 0. Din=0x00 and Din=0xFF -> parity bit 1.
- Handshake:
  - Hold Send=1 for 200000 cycles -> exactly one frame.
  - Pulse Send for 1 cycle -> full frame, Sent high for 1 cycle.
  - Change Din mid-frame -> transmitted bits unchanged.
- Async reset mid-frame: assert Reset during D3 between clock edges -> Sout=1 and Busy=0 immediately. A new Send after release gives a clean full frame.
- Loopback into the receiver: Din 0x00, 0x55, 0xA5, 0xFF back to back -> receiver Dout matches each byte, parityErr=0.
  - With UART_TX_TWO_STOP_EN: same results; stop interval measured at 10416 cycles.
